// File: rtl/prog_loader.sv
// prog_loader: turns a framed byte stream (SYNC, LEN_HI, LEN_LO, 4*N payload bytes) into 32-bit BRAM
// word writes and holds the CPU in reset until a good load. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte.
module prog_loader #(
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_BITS = 9,
  parameter int unsigned BASE_ADDR     = 0,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     err
);
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned MAX_WORDS = (32'd1 << RAM_ADDR_BITS) - BASE_ADDR;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR} state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = CSUM;
`else
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t                   state_q, state_d;
  logic                     in_ready_d, mem_we_d, cpu_reset_d, done_d, err_d;
  logic [RAM_ADDR_BITS-1:0] mem_addr_d;
  logic [RAM_WIDTH-1:0]     mem_wdata_d;
  logic [LEN_W-1:0]         len_q, len_d, cnt_q, cnt_d, len_full;
  logic [1:0]               byte_q, byte_d;
  logic                     accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d;
`endif

  assign accept   = in_valid && in_ready;
  assign len_full = {len_q[LEN_W-1:8], in_data};

  // Next-state and next-output logic; every register is loaded from its _d value.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b1;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    err_d       = err;
    len_d       = len_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d     = LEN_HI;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d  = len_full;
          cnt_d  = '0;
          byte_d = 2'd0;
          if (len_full == '0)                  state_d = PAYLOAD_END;
          else if (32'(len_full) > MAX_WORDS)  state_d = ERR;
          else                                 state_d = DATA;
        end
      end
      DATA: begin
        // Sync byte is plain payload here; words arrive MSB first.
        if (accept) begin
          mem_wdata_d = {mem_wdata[RAM_WIDTH-9:0], in_data};
          byte_d      = byte_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
          if (byte_q == 2'd3) begin
            state_d    = WRITE;
            mem_addr_d = RAM_ADDR_BITS'(BASE_ADDR) + RAM_ADDR_BITS'(cnt_q);
          end
        end
      end
      WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_d == len_q) ? PAYLOAD_END : DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered.
    if (state_d == WRITE) begin
      in_ready_d = 1'b0;
      mem_we_d   = 1'b1;
    end
    if (state_d == DONE) begin
      done_d      = 1'b1;
      cpu_reset_d = 1'b0;
    end
    if (state_d == ERR) begin
      err_d       = 1'b1;
      cpu_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RAM_ADDR_BITS'(BASE_ADDR);
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      byte_q    <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_reset <= cpu_reset_d;
      done      <= done_d;
      err       <= err_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule
